// File: rtl/itr_pkg.sv
// Shared FSM type and vector helpers for the interrupt controller.
// ITR_NEST_EN enables nested acceptance with an SDEPTH-deep return stack.
package itr_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_RET
   } itr_state_t;

   localparam int unsigned VEC_STRIDE = 1;

`ifdef ITR_NEST_EN
   localparam bit NEST_EN = 1'b1;
`else
   localparam bit NEST_EN = 1'b0;
`endif

   function automatic int unsigned vec_ofs(
      input int unsigned base,
      input int unsigned ch
   );
      return base + ch * VEC_STRIDE;
   endfunction

   function automatic int unsigned stack_depth(
      input int unsigned req
   );
      return NEST_EN ? req : 1;
   endfunction

endpackage

// File: rtl/itr_stack.sv
// Return-address LIFO: W bits wide, DEPTH entries, push/pop/top.
// Top reads as zero while empty.
module itr_stack #(
   parameter int unsigned W     = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW =
      (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] cnt;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   assign wr_idx = AW'(cnt);
   assign rd_idx = AW'(cnt - CW'(1));
   assign full   = (cnt == CW'(DEPTH));
   assign empty  = (cnt == '0);
   assign top    = empty ? '0 : mem[rd_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (push && !full) begin
         cnt <= cnt + CW'(1);
      end else if (pop && !empty) begin
         cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/itr_ctrl.sv
// Vectored interrupt controller: edge latch, fixed priority, return stack.
// ITR_NEST_EN: nested acceptance up to SDEPTH; otherwise one at a time.
module itr_ctrl
   import itr_pkg::*;
#(
   parameter int unsigned MINSTW  = 9,
   parameter int unsigned NUITR   = 4,
   parameter int unsigned SDEPTH  = 4,
   parameter int unsigned ITRBASE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUITR-1:0]  itr_in,
   input  logic [NUITR-1:0]  itr_mask,
   input  logic [MINSTW-1:0] pc_addr,
   input  logic              ready,
   input  logic              reti,
   output logic              itr_req,
   output logic [MINSTW-1:0] itr_vec,
   output logic              ret_load,
   output logic [MINSTW-1:0] ret_addr,
   output logic [NUITR-1:0]  active,
   output logic [NUITR-1:0]  pending,
   output logic              err
);

   localparam int unsigned KW =
      (NUITR > 1) ? $clog2(NUITR) : 1;
   localparam int unsigned DEPTH = stack_depth(SDEPTH);

   itr_state_t state;
   itr_state_t state_n;

   logic [NUITR-1:0]  smp;
   logic [NUITR-1:0]  smp_q;
   logic [NUITR-1:0]  edg;
   logic [NUITR-1:0]  pend_q;
   logic [NUITR-1:0]  act_q;
   logic [NUITR-1:0]  act_lsb;
   logic [NUITR-1:0]  below;
   logic [NUITR-1:0]  elig;
   logic [NUITR-1:0]  sel_oh;
   logic [NUITR-1:0]  clr;
   logic [KW-1:0]     pick;
   logic [KW-1:0]     sel_q;
   logic              reti_q;
   logic              err_q;
   logic              push;
   logic              full;
   logic              empty;
   logic [MINSTW-1:0] top;

   itr_stack #(
      .W     (MINSTW),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (ret_load),
      .din   (pc_addr),
      .top   (top),
      .full  (full),
      .empty (empty)
   );

   // Two sample stages: an edge is a fresh high sample over a low one.
   assign edg     = smp & ~smp_q;
   assign act_lsb = act_q & (~act_q + NUITR'(1));
   assign sel_oh  = NUITR'(1) << sel_q;
   assign clr     = (state == S_REQ) ? sel_oh : '0;

`ifdef ITR_NEST_EN
   assign below = (act_q == '0) ? '1 : act_lsb - NUITR'(1);
`else
   assign below = (act_q == '0) ? '1 : '0;
`endif

   assign elig = pend_q & itr_mask & below;

   always_comb begin
      pick = '0;
      for (int i = NUITR - 1; i >= 0; i--) begin
         if (elig[i]) pick = KW'(i);
      end
   end

   always_comb begin
      state_n = state;
      push    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (reti || reti_q) begin
               state_n = S_RET;
            end else if (ready && |elig && !full) begin
               state_n = S_REQ;
            end
         end
         S_REQ: begin
            push    = 1'b1;
            state_n = S_HOLD;
         end
         S_HOLD:  state_n = S_IDLE;
         S_RET:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         smp    <= '0;
         smp_q  <= '0;
         pend_q <= '0;
         act_q  <= '0;
         sel_q  <= '0;
         reti_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_n;
         smp    <= itr_in;
         smp_q  <= smp;
         pend_q <= (pend_q & ~clr) | edg;
         if (state == S_IDLE) begin
            sel_q  <= pick;
            reti_q <= 1'b0;
         end else if (reti) begin
            reti_q <= 1'b1;
         end
         if (state == S_REQ) begin
            act_q <= act_q | sel_oh;
         end else if (ret_load) begin
            act_q <= act_q & ~act_lsb;
         end
         if (state == S_RET && empty) begin
            err_q <= 1'b1;
         end
      end
   end

   assign itr_req  = (state == S_REQ);
   assign itr_vec  = itr_req ?
      MINSTW'(vec_ofs(ITRBASE, 32'(sel_q))) : '0;
   assign ret_load = (state == S_RET) && !empty;
   assign ret_addr = ret_load ? top : '0;
   assign active   = act_q;
   assign pending  = pend_q;
   assign err      = err_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Bench for itr_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_itr_ctrl;

   localparam int N     = 4;
   localparam int W     = 9;
   localparam int BASE  = 1;
   localparam int DEPTH = 4;
`ifdef ITR_NEST_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif
   localparam int CAP = NEST ? DEPTH : 1;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] itr_in;
   logic [N-1:0] itr_mask;
   logic [W-1:0] pc_addr;
   logic         ready;
   logic         reti;
   logic         itr_req;
   logic [W-1:0] itr_vec;
   logic         ret_load;
   logic [W-1:0] ret_addr;
   logic [N-1:0] active;
   logic [N-1:0] pending;
   logic         err;

   int total = 0;
   int bad   = 0;

   itr_ctrl #(
      .MINSTW  (W),
      .NUITR   (N),
      .SDEPTH  (DEPTH),
      .ITRBASE (BASE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .itr_in   (itr_in),
      .itr_mask (itr_mask),
      .pc_addr  (pc_addr),
      .ready    (ready),
      .reti     (reti),
      .itr_req  (itr_req),
      .itr_vec  (itr_vec),
      .ret_load (ret_load),
      .ret_addr (ret_addr),
      .active   (active),
      .pending  (pending),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Reference model: channels in service as a queue, return addresses
   // as a queue, and the kind of cycle the controller is in next.
   bit [N-1:0] s_new, s_old, m_pend, m_edge;
   int         m_act[$];
   bit [W-1:0] m_ret[$];
   bit         m_err, m_reti;
   bit         c_req, c_flush, c_ret;
   bit         n_req, n_flush, n_ret, idle;
   int         c_ch, pick, amin, lo;

   function automatic logic [N-1:0] act_bits();
      logic [N-1:0] r;
      r = '0;
      foreach (m_act[i]) r[m_act[i]] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_new = '0; s_old = '0; m_pend = '0;
         m_act.delete(); m_ret.delete();
         m_err = 0; m_reti = 0;
         c_req = 0; c_flush = 0; c_ret = 0; c_ch = 0;
      end else begin
         idle = !(c_req || c_flush || c_ret);
         n_req = 0; n_flush = c_req; n_ret = 0; pick = -1;
         amin = N;
         foreach (m_act[i]) if (m_act[i] < amin) amin = m_act[i];
         if (idle) begin
            if (reti || m_reti) begin
               n_ret = 1; m_reti = 0;
            end else if (ready && m_act.size() < CAP) begin
               for (int k = 0; k < N; k++)
                  if (pick < 0 && m_pend[k] && itr_mask[k] && k < amin)
                     pick = k;
               n_req = (pick >= 0);
            end
         end else if (reti) begin
            m_reti = 1;
         end
         m_edge = s_new & ~s_old;
         s_old = s_new; s_new = itr_in;
         if (c_req) begin
            m_pend[c_ch] = 1'b0;
            m_act.push_back(c_ch);
            m_ret.push_back(pc_addr);
         end
         if (c_ret) begin
            if (m_ret.size() > 0) begin
               void'(m_ret.pop_back());
               lo = 0;
               foreach (m_act[i]) if (m_act[i] < m_act[lo]) lo = i;
               m_act.delete(lo);
            end else begin
               m_err = 1;
            end
         end
         m_pend |= m_edge;
         c_req = n_req; c_flush = n_flush; c_ret = n_ret;
         if (n_req) c_ch = pick;
      end
   end

   always @(negedge clk) begin
      logic         e_rl;
      logic [W-1:0] e_vec, e_ra;
      e_rl  = c_ret && m_ret.size() > 0;
      e_vec = c_req ? W'(BASE + c_ch) : '0;
      e_ra  = e_rl ? m_ret[m_ret.size() - 1] : '0;
      chk("m_itr_req", 32'(itr_req), 32'(c_req));
      chk("m_itr_vec", 32'(itr_vec), 32'(e_vec));
      chk("m_ret_load", 32'(ret_load), 32'(e_rl));
      chk("m_ret_addr", 32'(ret_addr), 32'(e_ra));
      chk("m_active", 32'(active), 32'(act_bits()));
      chk("m_pending", 32'(pending), 32'(m_pend));
      chk("m_err", 32'(err), 32'(m_err));
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reti();
      reti = 1'b1;
      tick(1);
      reti = 1'b0;
   endtask

   task automatic wait_req(input string name, input logic [W-1:0] vec);
      bit got;
      got = 0;
      for (int i = 0; i < 12; i++) begin
         if (itr_req === 1'b1) begin
            got = 1;
            break;
         end
         tick(1);
      end
      chk({name, "_req"}, 32'(got), 32'd1);
      chk({name, "_vec"}, 32'(itr_vec), 32'(vec));
   endtask

   task automatic drain();
      itr_in = '0;
      repeat (10) begin
         tick(3);
         if (active != '0 && itr_req !== 1'b1) pulse_reti();
      end
      chk("drain_active", 32'(active), 32'd0);
   endtask

   initial begin
      rst = 1'b0; itr_in = '0; itr_mask = 4'hF;
      pc_addr = '0; ready = 1'b1; reti = 1'b0;
      tick(2);
      chk("rst_req", 32'(itr_req), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      rst = 1'b1;
      tick(2);

      // single service, latency and return
      pc_addr = 9'h040; itr_in = 4'b0100;
      tick(2);
      chk("lat_early", 32'(itr_req), 32'd0);
      tick(1);
      chk("s1_req", 32'(itr_req), 32'd1);
      chk("s1_vec", 32'(itr_vec), 32'd3);
      itr_in = '0;
      tick(1);
      chk("s1_act", 32'(active), 32'h4);
      tick(1);
      pulse_reti();
      chk("s1_rl", 32'(ret_load), 32'd1);
      chk("s1_ra", 32'(ret_addr), 32'h40);
      tick(1);
      chk("s1_act0", 32'(active), 32'd0);

      // simultaneous edges: lower index first
      pc_addr = 9'h0A5; itr_in = 4'b1010;
      wait_req("s2a", 9'd2);
      itr_in = '0;
      tick(2);
      chk("s2_pend", 32'(pending), 32'h8);
      pulse_reti();
      wait_req("s2b", 9'd4);
      drain();

      // higher priority arrives while a channel is in service
      pc_addr = 9'h111; itr_in = 4'b0100;
      wait_req("s3a", 9'd3);
      itr_in = '0;
      tick(2);
      pc_addr = 9'h122; itr_in = 4'b0001;
      if (NEST) begin
         wait_req("s3n", 9'd1);
         tick(1);
         chk("s3n_act", 32'(active), 32'h5);
      end else begin
         tick(6);
         chk("s3_wait", 32'(itr_req), 32'd0);
         chk("s3_pend", 32'(pending), 32'h1);
         pulse_reti();
         wait_req("s3f", 9'd1);
      end
      drain();

      // masked channel, then not ready
      itr_mask = 4'b1110; itr_in = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("mask_hold", 32'(itr_req), 32'd0);
      end
      chk("mask_pend", 32'(pending), 32'h1);
      itr_mask = 4'hF; ready = 1'b0;
      tick(3);
      chk("not_ready", 32'(itr_req), 32'd0);
      ready = 1'b1;
      wait_req("s4", 9'd1);
      drain();

      // reti with empty stack
      pulse_reti();
      chk("e_rl", 32'(ret_load), 32'd0);
      tick(1);
      chk("e_err", 32'(err), 32'd1);
      rst = 1'b0;
      #1;
      chk("e_clr", 32'(err), 32'd0);
      tick(1);
      rst = 1'b1;
      tick(1);

      // rapid toggling on one channel
      for (int i = 0; i < 10; i++) begin
         pc_addr = W'(9'h050 + i);
         itr_in = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         tick(1);
      end
      drain();

      // reset during the request cycle
      itr_in = 4'b0010;
      wait_req("s7", 9'd2);
      rst = 1'b0; itr_in = '0;
      #1;
      chk("r_req", 32'(itr_req), 32'd0);
      chk("r_vec", 32'(itr_vec), 32'd0);
      chk("r_act", 32'(active), 32'd0);
      chk("r_pend", 32'(pending), 32'd0);
      tick(2);
      rst = 1'b1;
      tick(4);
      chk("r_after", 32'(itr_req), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/itr_ctrl.md
ITR_CTRL -- requirements
Module: itr_ctrl

Interface
REQ-001 Parameter MINSTW, default 9, instruction address width.
REQ-002 Parameter NUITR, default 4, interrupt channel count (1..16).
REQ-003 Parameter SDEPTH, default 4, maximum nesting depth (return-address entries).
REQ-004 Parameter ITRBASE, default 1, vector base; channel k vector = ITRBASE + k.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-007 itr_in  in  NUITR  synchronous interrupt lines, rising-edge triggered.
REQ-008 itr_mask  in  NUITR  per-channel enable (1 = may be accepted).
REQ-009 pc_addr  in  MINSTW  address of next instruction to resume.
REQ-010 ready  in  1  core at instruction boundary, no jump in flight.
REQ-011 reti  in  1  one-cycle pulse, return-from-interrupt decoded.
REQ-012 itr_req  out  1  one-cycle force-load to prefetch.
REQ-013 itr_vec  out  MINSTW  vector address, valid while itr_req=1.
REQ-014 ret_load  out  1  one-cycle force-load of return address.
REQ-015 ret_addr  out  MINSTW  return address, valid while ret_load=1.
REQ-016 active  out  NUITR  channels currently in service.
REQ-017 pending  out  NUITR  latched, not-yet-accepted requests.
REQ-018 err  out  1  sticky: reti with empty return stack.

Function
REQ-019 Rising edge (itr_in=1, previous sample 0) sets pending[k] at the next clock edge; a repeated edge on a pending channel is absorbed (no count).
REQ-020 Masked channels latch pending but are never accepted until unmasked.
REQ-021 Priority fixed: lower index wins; eligible k = pending & mask, index below lowest set bit of active (any k if active=0).
REQ-022 FSM states IDLE, REQ, HOLD, RET; reset state IDLE.
REQ-023 IDLE -> RET when reti=1 (reti beats acceptance in the same cycle; acceptance deferred).
REQ-024 IDLE -> REQ when ready=1, an eligible channel exists, stack not full.
REQ-025 REQ (one cycle): itr_req=1, itr_vec=ITRBASE+k, push pc_addr, set active[k], clear pending[k]; -> HOLD.
REQ-026 New edge on channel k during its REQ cycle leaves pending[k]=1.
REQ-027 HOLD (one cycle, prefetch flush, no acceptance); -> IDLE; reti arriving in REQ/HOLD is latched and served on return to IDLE.
REQ-028 RET (one cycle): ret_load=1, ret_addr=stack top, pop, clear lowest set bit of active; -> IDLE.
REQ-029 reti with empty stack: no pop, ret_load=0, err set, -> IDLE.
REQ-030 Latency: itr_in first sampled high at edge t -> itr_req high in cycle after edge t+2 if ready stays 1.
REQ-031 Stack full (SDEPTH entries): higher-priority requests stay pending, no error.
REQ-032 itr_vec and ret_addr are zero whenever their strobe is low.

Reset
REQ-033 rst=0 asynchronously clears pending, active, err, stack pointer, edge history, all strobes; FSM to IDLE; no itr_req/ret_load emitted mid-operation.

Configuration
REQ-034 Macro ITR_NEST_EN defined: nesting per REQ-021 up to SDEPTH.
REQ-035 ITR_NEST_EN undefined: no acceptance while active!=0; stack depth fixed 1; SDEPTH ignored.

Structure
REQ-036 Package itr_pkg holds FSM state enum and vector-offset helper constants.
REQ-037 Sub-module itr_stack: parametrised LIFO (MINSTW wide, SDEPTH deep) with push, pop, top, full, empty.

Verification (NUITR=4, ITRBASE=1, MINSTW=9, mask=4'hF)
REQ-038 Edge ch2, pc_addr=0x40, ready=1 -> itr_req pulse, itr_vec=3, active=4'b0100; reti -> ret_load, ret_addr=0x40, active=0.
REQ-039 Edges ch1 and ch3 same cycle -> ch1 served first (vec 2); ch3 stays pending, served after reti.
REQ-040 In service ch2, edge ch0 -> nested accept, vec 1, active=4'b0101 (ITR_NEST_EN); without macro ch0 waits for reti.
REQ-041 mask=4'b1110, edge ch0 -> pending[0]=1, no itr_req; mask=4'hF -> accepted.
REQ-042 reti with active=0 -> err=1, ret_load=0; rst=0 clears err.
REQ-043 rst=0 asserted during REQ -> all outputs zero immediately, FSM IDLE after release.
